nco_sweep_ctrl: RTL and testbench

Sequencer that drives the tuning word and accumulator reset of the basic NCO. It accepts one sweep command at a time over a valid/ready handshake and can produce either a fixed tone or a linear frequency sweep. A sweep is a start tuning word, a signed step, a step count and a dwell length counted in ce cycles. It sits between the control/register logic and the NCO i_tune/reset inputs, and shares the NCO's clk and ce.

---
 rtl/nco_sweep_ctrl.sv | 94 +++++++++
 tb/tb_nco_sweep_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl.sv
// Sweep sequencer for the basic NCO: accepts one command at a time and steps
// the tuning word through count+1 values, each held for dwell+1 ce cycles.
module nco_sweep_ctrl #(
  parameter int ACC_W   = 32,
  parameter int CNT_W   = 16,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ACC_W-1:0]   cmd_start,
  input  logic [ACC_W-1:0]   cmd_step,
  input  logic [CNT_W-1:0]   cmd_count,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic               cmd_phase_rst,
  input  logic               abort,
  output logic [ACC_W-1:0]   o_tune,
  output logic               o_nco_reset,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [ACC_W-1:0]   tune_q;
  logic [ACC_W-1:0]   step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_cnt_q;
  logic [CNT_W-1:0]   steps_left_q;
  logic               nco_rst_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tune_q       <= '0;
      step_q       <= '0;
      dwell_q      <= '0;
      dwell_cnt_q  <= '0;
      steps_left_q <= '0;
      nco_rst_q    <= 1'b0;
    end else begin
      nco_rst_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            tune_q       <= cmd_start;
            step_q       <= cmd_step;
            dwell_q      <= cmd_dwell;
            dwell_cnt_q  <= cmd_dwell;
            steps_left_q <= cmd_count;
            nco_rst_q    <= cmd_phase_rst;
            state_q      <= S_DWELL;
          end
        end
        S_DWELL: begin
          // abort takes priority over a coincident ce, so no step is taken
          if (abort) begin
            state_q <= S_IDLE;
          end else if (ce) begin
            if (dwell_cnt_q != '0) begin
              dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
            end else if (steps_left_q != '0) begin
              tune_q       <= tune_q + step_q;
              steps_left_q <= steps_left_q - CNT_W'(1);
              dwell_cnt_q  <= dwell_q;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign o_busy      = (state_q == S_DWELL);
  assign o_done      = (state_q == S_DONE);
  assign o_tune      = tune_q;
  assign o_nco_reset = nco_rst_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Randomised scoreboard bench for nco_sweep_ctrl: each accepted command is
// expanded into expected (tune, ce-hold) segments that a monitor checks.
module tb_nco_sweep_ctrl;
  localparam int ACC_W   = 32;
  localparam int CNT_W   = 16;
  localparam int DWELL_W = 16;

  logic clk = 1'b0;
  logic reset, ce, cmd_valid, cmd_ready, cmd_phase_rst, abort;
  logic o_nco_reset, o_busy, o_done;
  logic [ACC_W-1:0]   cmd_start, cmd_step, o_tune;
  logic [CNT_W-1:0]   cmd_count;
  logic [DWELL_W-1:0] cmd_dwell;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  // kind 0: a tuning value held for cnt ce cycles; kind 1: completion pulse
  typedef struct {
    int          kind;
    logic [31:0] tune;
    int          cnt;
    bit          nrst;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  nco_sweep_ctrl #(.ACC_W(ACC_W), .CNT_W(CNT_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_step(cmd_step),
    .cmd_count(cmd_count), .cmd_dwell(cmd_dwell),
    .cmd_phase_rst(cmd_phase_rst), .abort(abort),
    .o_tune(o_tune), .o_nco_reset(o_nco_reset),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic [31:0] cur_tune;
  int          cur_cnt;
  bit          in_seg = 1'b0;

  task automatic open_seg();
    in_seg   = 1'b1;
    cur_tune = o_tune;
    cur_cnt  = 0;
    if (exp_q.size() == 0 || exp_q[0].kind != 0) begin
      chk("segment_expected", 32'(0), 32'(1));
    end else begin
      chk("nco_reset_pulse", 32'(o_nco_reset), 32'(exp_q[0].nrst));
      if (exp_q[0].cyc >= 0) chk("accept_latency", 32'(cyc), 32'(exp_q[0].cyc));
    end
  endtask

  task automatic close_seg();
    in_seg = 1'b0;
    if (exp_q.size() == 0 || exp_q[0].kind != 0) begin
      chk("segment_close_expected", 32'(0), 32'(1));
    end else begin
      chk("seg_tune", cur_tune, exp_q[0].tune);
      chk("seg_ce_hold", 32'(cur_cnt), 32'(exp_q[0].cnt));
      void'(exp_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (!mon_en || reset) begin
      in_seg = 1'b0;
    end else begin
      if (o_busy) begin
        if (!in_seg || o_tune !== cur_tune) begin
          if (in_seg) close_seg();
          open_seg();
        end else begin
          chk("nco_reset_quiet", 32'(o_nco_reset), 32'(0));
        end
        if (ce && !abort) cur_cnt++;
      end else begin
        if (in_seg) begin
          chk("tune_hold", o_tune, cur_tune);
          close_seg();
        end
        chk("nco_reset_quiet", 32'(o_nco_reset), 32'(0));
      end
      if (o_done) begin
        if (exp_q.size() == 0) begin
          chk("done_expected", 32'(0), 32'(1));
        end else begin
          chk("done_order", 32'(exp_q[0].kind), 32'(1));
          if (exp_q[0].kind == 1) begin
            if (exp_q[0].cyc >= 0) chk("done_cycle", 32'(cyc), 32'(exp_q[0].cyc));
            void'(exp_q.pop_front());
          end
        end
      end
      chk("cmd_ready", 32'(cmd_ready), 32'(!(o_busy || o_done)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic summary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      ce        = 1'($urandom_range(1));
      abort     = 1'($urandom_range(1));
    end
  endtask

  // Holds the command until accepted; T is the handshake cycle, ok=0 on timeout.
  task automatic accept(input logic [31:0] st, input logic [31:0] sp, input int cnt,
                        input int dw, input bit prst, output int t, output bit ok);
    bit hs = 1'b0;
    int waitc = 0;
    ok = 1'b1;
    t  = 0;
    while (!hs) begin
      @(posedge clk); #1;
      cmd_valid     = 1'b1;
      cmd_start     = st;
      cmd_step      = sp;
      cmd_count     = CNT_W'(cnt);
      cmd_dwell     = DWELL_W'(dw);
      cmd_phase_rst = prst;
      ce            = 1'($urandom_range(1));
      abort         = ($urandom_range(3) == 0);
      if (cmd_ready) hs = 1'b1;
      waitc++;
      if (!hs && waitc > 200) begin
        chk("accept_timeout", 32'(0), 32'(1));
        cmd_valid = 1'b0;
        ok = 1'b0;
        return;
      end
    end
    t = cyc;
  endtask

  // mode 0: ce always high, 1: ce one cycle in four, 2: random ce
  task automatic run_cmd(input logic [31:0] st, input logic [31:0] sp, input int cnt,
                         input int dw, input bit prst, input int mode, input int ab_n);
    int   total = (cnt + 1) * (dw + 1);
    int   t, issued, phase, kk, rem;
    bit   ok;
    exp_t e;
    accept(st, sp, cnt, dw, prst, t, ok);
    if (!ok) return;
    kk  = (ab_n < 0) ? cnt + 1 : ab_n / (dw + 1);
    rem = (ab_n < 0) ? 0 : ab_n % (dw + 1);
    for (int k = 0; k < kk; k++) begin
      e.kind = 0; e.tune = st + sp * 32'(k); e.cnt = dw + 1;
      e.nrst = (k == 0) ? prst : 1'b0; e.cyc = (k == 0) ? t + 1 : -1;
      exp_q.push_back(e);
    end
    if (ab_n >= 0) begin
      e.kind = 0; e.tune = st + sp * 32'(kk); e.cnt = rem;
      e.nrst = (kk == 0) ? prst : 1'b0; e.cyc = (kk == 0) ? t + 1 : -1;
      exp_q.push_back(e);
    end else begin
      e.kind = 1; e.tune = '0; e.cnt = 0; e.nrst = 1'b0;
      e.cyc = (mode == 0) ? t + total + 1 : (mode == 1) ? t + 4 * total + 1 : -1;
      exp_q.push_back(e);
    end
    $display("cmd start=%h step=%h count=%0d dwell=%0d prst=%0d mode=%0d abort_after=%0d at cycle %0d",
             st, sp, cnt, dw, prst, mode, ab_n, t);
    issued = 0;
    phase  = 0;
    forever begin
      @(posedge clk); #1;
      cmd_valid     = 1'($urandom_range(1));
      cmd_start     = $urandom;
      cmd_step      = $urandom;
      cmd_count     = CNT_W'($urandom_range(7));
      cmd_dwell     = DWELL_W'($urandom_range(3));
      cmd_phase_rst = 1'($urandom_range(1));
      case (mode)
        0:       ce = 1'b1;
        1:       ce = (phase % 4 == 3);
        default: ce = 1'($urandom_range(1));
      endcase
      phase++;
      abort = 1'b0;
      if (ce && ab_n >= 0 && issued == ab_n) begin
        abort = 1'b1;
        break;
      end
      if (ce) issued++;
      if (issued == total) break;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || in_seg) && n < 1000) begin
      idle_cycles(1);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    summary();
    $finish;
  end

  initial begin
    int          t, cnt, dw, ab;
    bit          ok;
    logic [31:0] st, sp;
    reset = 1'b1; ce = 1'b0; cmd_valid = 1'b0; abort = 1'b0; cmd_phase_rst = 1'b0;
    cmd_start = '0; cmd_step = '0; cmd_count = '0; cmd_dwell = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_tune", o_tune, 32'(0));
    chk("reset_ready", 32'(cmd_ready), 32'(1));
    chk("reset_busy", 32'(o_busy), 32'(0));
    chk("reset_done", 32'(o_done), 32'(0));
    chk("reset_nco_reset", 32'(o_nco_reset), 32'(0));
    reset  = 1'b0;
    mon_en = 1'b1;

    run_cmd(32'h0100_0000, 32'h0010_0000, 3, 1, 1'b0, 0, -1);
    run_cmd(32'h0100_0000, 32'h0010_0000, 3, 1, 1'b0, 1, -1);
    run_cmd(32'h0000_0010, 32'hFFFF_FFF0, 2, 0, 1'b0, 0, -1);
    run_cmd(32'h0100_0000, 32'h0010_0000, 3, 1, 1'b1, 0, 3);
    run_cmd(32'h4000_0000, 32'h0000_0000, 0, 0, 1'b0, 0, -1);

    for (int i = 0; i < 40; i++) begin
      st  = $urandom;
      sp  = $urandom;
      if (sp == 0) sp = 32'h1;
      cnt = $urandom_range(5);
      dw  = $urandom_range(3);
      ab  = ($urandom_range(3) == 0) ? int'($urandom_range((cnt + 1) * (dw + 1) - 1)) : -1;
      run_cmd(st, sp, cnt, dw, 1'($urandom_range(1)), $urandom_range(2), ab);
    end
    wait_drain();

    // reset in the middle of a sweep discards it and clears the tuning word
    mon_en = 1'b0;
    accept(32'h1234_5678, 32'h0000_1000, 5, 3, 1'b0, t, ok);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      ce        = 1'b1;
      abort     = 1'b0;
      reset     = (i == 5);
    end
    @(negedge clk);
    chk("pre_reset_tune", o_tune, 32'h1234_6678);
    @(posedge clk); #1;
    reset = 1'b0;
    ce    = 1'b0;
    @(negedge clk);
    chk("mid_reset_tune", o_tune, 32'(0));
    chk("mid_reset_busy", 32'(o_busy), 32'(0));
    chk("mid_reset_ready", 32'(cmd_ready), 32'(1));
    mon_en = 1'b1;

    run_cmd(32'h0ABC_0000, 32'h0000_0100, 2, 1, 1'b1, 2, -1);
    idle_cycles(1);
    wait_drain();
    idle_cycles(4);
    summary();
    $finish;
  end

endmodule
